// File: rtl/numeric_entry_pkg.sv
// Shared scan-code constants, entry FSM state encoding and digit-key decode
// for the PS/2 numeric-entry controllers.
package numeric_entry_pkg;

  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_EDIT = 2'b10
  } state_t;

  // {valid, digit}: main-row and keypad digits; caller must qualify with ext=0
  function automatic logic [4:0] decode_digit(input logic [7:0] code);
    case (code)
      8'h45, 8'h70: return 5'h10;
      8'h16, 8'h69: return 5'h11;
      8'h1E, 8'h72: return 5'h12;
      8'h26, 8'h7A: return 5'h13;
      8'h25, 8'h6B: return 5'h14;
      8'h2E, 8'h73: return 5'h15;
      8'h36, 8'h74: return 5'h16;
      8'h3D, 8'h6C: return 5'h17;
      8'h3E, 8'h75: return 5'h18;
      8'h46, 8'h7D: return 5'h19;
      default:      return 5'h00;
    endcase
  endfunction

endpackage

// File: rtl/numeric_entry_bin_to_bcd.sv
// Combinational double-dabble converter used to show the committed value.
module numeric_entry_bin_to_bcd #(
  parameter int IN_W       = 10,
  parameter int NUM_DIGITS = 3
) (
  input  logic [IN_W-1:0]         bin,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  logic [4*NUM_DIGITS+IN_W-1:0] sr;

  always_comb begin
    sr = '0;
    sr[IN_W-1:0] = bin;
    for (int i = 0; i < IN_W; i++) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (sr[IN_W+4*d +: 4] >= 4'd5)
          sr[IN_W+4*d +: 4] = sr[IN_W+4*d +: 4] + 4'd3;
      end
      sr = sr << 1;
    end
    bcd = sr[IN_W +: 4*NUM_DIGITS];
  end

endmodule

// File: rtl/numeric_entry.sv
// PS/2 numeric-entry controller: collects decimal digits, supports backspace,
// escape and arrow nudges, and commits a range-clamped binary value.
//   state | meaning
//   IDLE  | showing committed Value; arrows nudge it, a digit starts an edit
//   EDIT  | digits being collected in the BCD buffer
module numeric_entry
  import numeric_entry_pkg::*;
#(
  parameter int NUM_DIGITS  = 3,
  parameter int VAL_W       = 10,
  parameter int MIN_VAL     = 40,
  parameter int MAX_VAL     = 240,
  parameter int DEFAULT_VAL = 120,
  parameter int STEP        = 1
) (
  input  logic                    Clock,
  input  logic                    nReset,
  input  logic                    Enable,
  input  logic [7:0]              data,
  input  logic                    data_en,
  output logic [VAL_W-1:0]        Value,
  output logic                    value_valid,
  output logic                    clamped,
  output logic                    editing,
  output logic [2:0]              digit_count,
  output logic [4*NUM_DIGITS-1:0] disp_bcd
);

  localparam int BUF_W = 4*NUM_DIGITS;

  state_t            state;
  logic [BUF_W-1:0]  buffer;
  logic              brk, ext;
  logic [4:0]        key_dig;
  logic              is_key, is_digit;
  logic [31:0]       bin, up_raw, down_raw;
  logic [VAL_W:0]    commit_res, up_res, down_res;
  logic [BUF_W-1:0]  value_bcd;

  // {was_clamped, clamped_value}
  function automatic logic [VAL_W:0] clamp_val(input logic [31:0] x);
    if (x < 32'(MIN_VAL)) return {1'b1, VAL_W'(MIN_VAL)};
    if (x > 32'(MAX_VAL)) return {1'b1, VAL_W'(MAX_VAL)};
    return {1'b0, x[VAL_W-1:0]};
  endfunction

  always_comb begin
    key_dig  = decode_digit(data);
    is_key   = (data != SC_BRK) && (data != SC_EXT) && !brk;
    is_digit = key_dig[4] && !ext;

    bin = '0;
    for (int i = NUM_DIGITS-1; i >= 0; i--)
      bin = bin * 32'd10 + 32'(buffer[4*i +: 4]);

    // saturate at the register range before clamping so nothing can wrap
    up_raw = 32'(Value) + 32'(STEP);
    if (up_raw > 32'((1 << VAL_W) - 1)) up_raw = 32'((1 << VAL_W) - 1);
    down_raw = (32'(Value) < 32'(STEP)) ? 32'd0 : 32'(Value) - 32'(STEP);

    commit_res = clamp_val(bin);
    up_res     = clamp_val(up_raw);
    down_res   = clamp_val(down_raw);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state       <= ST_IDLE;
      buffer      <= '0;
      digit_count <= '0;
      brk         <= 1'b0;
      ext         <= 1'b0;
      Value       <= VAL_W'(DEFAULT_VAL);
      value_valid <= 1'b0;
      clamped     <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      clamped     <= 1'b0;

      if (data_en) begin
        if (data == SC_BRK)      brk <= 1'b1;
        else if (data == SC_EXT) ext <= 1'b1;
        else begin
          brk <= 1'b0;
          ext <= 1'b0;
        end
      end

      if (!Enable) begin
        state       <= ST_IDLE;
        buffer      <= '0;
        digit_count <= '0;
      end else if (data_en && is_key) begin
        case (state)
          ST_IDLE: begin
            if (is_digit) begin
              buffer      <= BUF_W'(key_dig[3:0]);
              digit_count <= 3'd1;
              state       <= ST_EDIT;
            end else if (ext && data == SC_UP) begin
              {clamped, Value} <= up_res;
              value_valid      <= 1'b1;
            end else if (ext && data == SC_DOWN) begin
              {clamped, Value} <= down_res;
              value_valid      <= 1'b1;
            end
          end
          ST_EDIT: begin
            if (is_digit) begin
              if (digit_count < 3'(NUM_DIGITS)) begin
                buffer      <= (buffer << 4) | BUF_W'(key_dig[3:0]);
                digit_count <= digit_count + 3'd1;
              end
            end else if (data == SC_BKSP) begin
              buffer      <= buffer >> 4;
              digit_count <= digit_count - 3'd1;
              if (digit_count == 3'd1) state <= ST_IDLE;
            end else if (data == SC_ESC) begin
              buffer      <= '0;
              digit_count <= '0;
              state       <= ST_IDLE;
            end else if (data == SC_ENTER) begin
              {clamped, Value} <= commit_res;
              value_valid      <= 1'b1;
              buffer           <= '0;
              digit_count      <= '0;
              state            <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign editing  = (state == ST_EDIT);
  assign disp_bcd = editing ? buffer : value_bcd;

  numeric_entry_bin_to_bcd #(
    .IN_W       (VAL_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bcd (
    .bin (Value),
    .bcd (value_bcd)
  );

endmodule

// File: tb/tb_numeric_entry.sv
// Directed bench for numeric_entry; commits and nudges are checked by a
// scoreboard monitor, display/state checks are made inline.
module tb_numeric_entry;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        Enable;
  logic [7:0]  data;
  logic        data_en;
  logic [9:0]  Value;
  logic        value_valid;
  logic        clamped;
  logic        editing;
  logic [2:0]  digit_count;
  logic [11:0] disp_bcd;

  typedef struct packed {
    logic [9:0] v;
    logic       c;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  numeric_entry dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .Enable      (Enable),
    .data        (data),
    .data_en     (data_en),
    .Value       (Value),
    .value_valid (value_valid),
    .clamped     (clamped),
    .editing     (editing),
    .digit_count (digit_count),
    .disp_bcd    (disp_bcd)
  );

  always #5 Clock = ~Clock;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(negedge Clock) begin
    if (nReset && value_valid) begin
      check("pulse_expected", int'(q.size() != 0), 1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("commit_value", int'(Value), int'(e.v));
        check("commit_clamped", int'(clamped), int'(e.c));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge Clock);
    data    = b;
    data_en = 1'b1;
    @(negedge Clock);
    data_en = 1'b0;
  endtask

  task automatic press(input logic [7:0] b, input bit e);
    if (e) send(8'hE0);
    send(b);
    if (e) send(8'hE0);
    send(8'hF0);
    send(b);
  endtask

  task automatic expect_commit(input int v, input bit c);
    q.push_back({10'(v), c});
  endtask

  initial begin
    nReset  = 1'b0;
    Enable  = 1'b1;
    data    = 8'h00;
    data_en = 1'b0;
    repeat (2) @(negedge Clock);
    check("rst_value", int'(Value), 120);
    check("rst_disp", int'(disp_bcd), 'h120);
    check("rst_editing", int'(editing), 0);
    check("rst_valid", int'(value_valid), 0);
    check("rst_count", int'(digit_count), 0);
    nReset = 1'b1;

    // main-row 1,5,0 then Enter
    press(8'h16, 0);
    check("edit_started", int'(editing), 1);
    press(8'h2E, 0);
    press(8'h45, 0);
    check("buf_150", int'(disp_bcd), 'h150);
    check("count_3", int'(digit_count), 3);
    expect_commit(150, 0);
    press(8'h5A, 0);
    check("idle_after_enter", int'(editing), 0);
    check("disp_150", int'(disp_bcd), 'h150);

    // keypad 8,5, backspace, keypad 0, extended Enter
    press(8'h75, 0);
    press(8'h73, 0);
    press(8'h66, 0);
    check("bksp_count", int'(digit_count), 1);
    check("bksp_buf", int'(disp_bcd), 'h008);
    press(8'h70, 0);
    check("kp_release_count", int'(digit_count), 2);
    expect_commit(80, 0);
    press(8'h5A, 1);
    check("value_80", int'(Value), 80);

    // 9,9,9 then ignored 4th digit, commit clamps high
    press(8'h46, 0);
    press(8'h46, 0);
    press(8'h46, 0);
    press(8'h3D, 0);
    check("full_buf", int'(disp_bcd), 'h999);
    check("full_count", int'(digit_count), 3);
    expect_commit(240, 1);
    press(8'h5A, 0);

    // nudges at the top bound
    expect_commit(240, 1);
    press(8'h75, 1);
    expect_commit(239, 0);
    press(8'h72, 1);
    expect_commit(238, 0);
    press(8'h72, 1);
    expect_commit(237, 0);
    press(8'h72, 1);
    check("disp_237", int'(disp_bcd), 'h237);

    // escape cancels with no pulse
    press(8'h36, 0);
    press(8'h45, 0);
    press(8'h76, 0);
    check("esc_idle", int'(editing), 0);
    check("esc_count", int'(digit_count), 0);
    check("esc_value", int'(Value), 237);

    // Enable low aborts; following Enter in IDLE does nothing
    press(8'h36, 0);
    check("en_edit", int'(editing), 1);
    @(negedge Clock);
    Enable = 1'b0;
    @(negedge Clock);
    Enable = 1'b1;
    check("en_abort_idle", int'(editing), 0);
    check("en_abort_count", int'(digit_count), 0);
    press(8'h5A, 0);
    check("en_value", int'(Value), 237);

    // backspace of the only digit returns to IDLE
    press(8'h1E, 0);
    press(8'h66, 0);
    check("bksp_to_idle", int'(editing), 0);

    // low-bound clamp on commit and on nudge
    press(8'h16, 0);
    expect_commit(40, 1);
    press(8'h5A, 0);
    expect_commit(40, 1);
    press(8'h72, 1);
    check("disp_040", int'(disp_bcd), 'h040);

    // async reset mid-edit
    press(8'h2E, 0);
    check("pre_rst_edit", int'(editing), 1);
    @(negedge Clock);
    nReset = 1'b0;
    #2;
    check("async_rst_value", int'(Value), 120);
    check("async_rst_editing", int'(editing), 0);
    check("async_rst_count", int'(digit_count), 0);
    @(negedge Clock);
    nReset = 1'b1;

    repeat (3) @(negedge Clock);
    check("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
